// File: rtl/memory_arbiter_pkg.sv
// Shared constants and types for the two-client memory arbiter.
// The read tag travels alongside each read so its data returns to the right client.
package memory_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 8;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic client;
  } read_tag_t;

  localparam read_tag_t TAG_NONE = '{valid: 1'b0, client: CLIENT0};

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin selector: masks out clients whose grant is still showing,
// then picks one winner (one-hot) and flips the priority pointer past it.
module rr_arbiter_2
  import memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] busy,
  output logic [1:0] grant
);

  logic [1:0] eligible;
  logic       ptr_reg;

  // A request seen while its own grant is high is the already-served one.
  assign eligible = req & ~busy;

  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = (ptr_reg == CLIENT1) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= CLIENT0;
    end else if (grant[0]) begin
      ptr_reg <= CLIENT1;
    end else if (grant[1]) begin
      ptr_reg <= CLIENT0;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one registered-read dual-port memory between two req/gnt clients.
// Reads return on rdata with a per-client rvalid three cycles after the request is sampled.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_w_en,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data
);

  logic [1:0]        grant;
  logic              any_grant;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // issue_tag sits beside the grant; tag_s1/tag_s2 follow the memory's two-cycle read.
  read_tag_t issue_tag_reg;
  read_tag_t tag_s1_reg;
  read_tag_t tag_s2_reg;

  rr_arbiter_2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   ({req1, req0}),
    .busy  ({gnt1, gnt0}),
    .grant (grant)
  );

  assign any_grant = |grant;
  assign sel       = grant[1] ? CLIENT1 : CLIENT0;
  assign sel_we    = (sel == CLIENT1) ? we1    : we0;
  assign sel_addr  = (sel == CLIENT1) ? addr1  : addr0;
  assign sel_wdata = (sel == CLIENT1) ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_addr <= '0;
      mem_w_data <= '0;
      mem_r_addr <= '0;
    end else begin
      gnt0     <= grant[0];
      gnt1     <= grant[1];
      mem_w_en <= any_grant & sel_we;
      mem_r_en <= any_grant & ~sel_we;
      if (any_grant && sel_we) begin
        mem_w_addr <= sel_addr;
        mem_w_data <= sel_wdata;
      end
      if (any_grant && !sel_we) begin
        mem_r_addr <= sel_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_tag_reg <= TAG_NONE;
      tag_s1_reg    <= TAG_NONE;
      tag_s2_reg    <= TAG_NONE;
    end else begin
      issue_tag_reg <= '{valid: any_grant & ~sel_we, client: sel};
      tag_s1_reg    <= issue_tag_reg;
      tag_s2_reg    <= tag_s1_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= tag_s2_reg.valid & (tag_s2_reg.client == CLIENT0);
      rvalid1 <= tag_s2_reg.valid & (tag_s2_reg.client == CLIENT1);
      if (tag_s2_reg.valid) begin
        rdata <= mem_r_data;
      end
    end
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-client round-robin arbiter that shares one 16 x 8 simple dual-port memory (registered read, one write port, one read port) between two requesters. Each client issues single read or write operations over a req/gnt handshake; the arbiter drives the memory control ports and returns read data to the issuing client. It sits between the client logic and the memory instance.

## Interface
- ADDR_W, 4, memory address width (depth 2^ADDR_W)
- DATA_W, 8, memory data width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- req0 / req1  in  1  client operation request, held until matching gnt
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  operation address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse, operation accepted
- rvalid0 / rvalid1  out  1  one-cycle pulse, rdata holds read result for that client
- rdata  out  DATA_W  read data, shared by both clients
- mem_w_en, mem_r_en  out  1  memory write/read enables
- mem_w_addr, mem_r_addr  out  ADDR_W  memory addresses
- mem_w_data  out  DATA_W  memory write data
- mem_r_data  in  DATA_W  memory read data, valid the cycle after the memory samples mem_r_en

## Operation
- At most one operation issued per cycle, to exactly one client.
- Eligibility: client i eligible when req_i = 1 and gnt_i is not currently high (req seen in the grant cycle is stale).
- Selection: one eligible client wins; both eligible -> client indicated by priority pointer wins; pointer then moves to the other client. Single eligible client wins regardless of pointer; pointer still moves to the other client.
- On grant (registered): gnt_i = 1; write -> mem_w_en = 1, mem_w_addr/mem_w_data from client; read -> mem_r_en = 1, mem_r_addr from client, issuing client index recorded in a 2-stage read tag pipeline.
- No grant: mem_w_en = mem_r_en = 0; address/data outputs hold previous values.
- Read return: when tag reaches stage 2, rdata <= mem_r_data and rvalid_i = 1 for the tagged client.
- Both clients continuously requesting -> strict alternation, memory busy every cycle.
- Reset (async, any time): gnt*, rvalid*, mem_w_en, mem_r_en = 0; mem_*_addr, mem_w_data, rdata = 0; tags cleared (in-flight reads dropped, no rvalid); pointer = client 0.

## Timing
- Edge N samples req; gnt and memory controls high during cycle N..N+1 (1-cycle request-to-grant latency).
- Memory acts at edge N+1 (write committed / read sampled).
- rvalid and rdata high during cycle after edge N+3: 3 cycles from sampling req to read data.
- Client holds req/we/addr/wdata until it sees gnt; at the edge ending the gnt cycle it may drop req or present the next operation.
- Read-after-write: write granted at edge N, read of same address granted at edge N+1 or later returns new data.
- Max rate per client: one grant every 2 cycles.
- rvalid0 and rvalid1 never high in the same cycle; gnt0 and gnt1 never high in the same cycle.

## Structure
- Shared package: ADDR_W, DATA_W defaults, client index constants (CLIENT0 = 0, CLIENT1 = 1), tag encoding (valid bit + client index).
- Sub-module rr_arbiter_2: eligibility mask, priority pointer register, one-hot grant select; memory_arbiter adds operation muxing, output registers and read tag pipeline.

## Test plan
- Reset: assert rst mid-read (tag in flight) -> all outputs 0 within same cycle, no rvalid after release, first grant with both requesting goes to client 0.
- Client 0 writes 0xA5 to 0x3, then reads 0x3 -> gnt0 pulse per op, mem_w_en pulse with addr 0x3/data 0xA5, rvalid0 three cycles after read sampled, rdata = 0xA5.
- Both clients request continuously (reads of 0x1 / 0x2 preloaded 0x11 / 0x22) -> gnt alternates 0,1,0,1; rvalid alternates with rdata 0x11, 0x22, no dropped or duplicated responses.
- Client 1 alone holds req for 4 ops -> gnt1 every other cycle, never two consecutive cycles.
- Client 0 writes 0x5A to 0xF while client 1 reads 0xF granted next cycle -> client 1 rvalid with rdata 0x5A.
- Address wrap: writes to 0x0 and 0xF, read back both -> correct data, no aliasing.
